// File: rtl/board_io_pkg.sv
// rtl/board_io_pkg.sv - shared encodings, segment table and FSM states for the board I/O front end
package board_io_pkg;

    localparam logic [1:0] MODE_HEX     = 2'b00;
    localparam logic [1:0] MODE_UDEC    = 2'b01;
    localparam logic [1:0] MODE_SDEC    = 2'b10;
    localparam logic [1:0] MODE_HEX_ALT = 2'b11;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_FMT
    } state_t;

    // Active-low gfedcba pattern for one hex nibble.
    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - single-channel button synchroniser and debouncer with press pulse
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;

    // Flipping on cnt == LAST gives DEBOUNCE_CYCLES consecutive mismatching cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            meta  <= raw;
            sync  <= meta;
            pulse <= 1'b0;
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                level <= sync;
                pulse <= sync;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/board_io_ctrl.sv
// rtl/board_io_ctrl.sv - button debounce bank plus hex/decimal seven-segment display driver
module board_io_ctrl
    import board_io_pkg::*;
#(
    parameter int NUM_BTN         = 3,
    parameter int NUM_DIGITS      = 4,
    parameter int DATA_WIDTH      = 16,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_BTN-1:0]      btn_raw,
    output logic [NUM_BTN-1:0]      btn_level,
    output logic [NUM_BTN-1:0]      btn_pulse,
    input  logic [DATA_WIDTH-1:0]   value,
    input  logic [1:0]              mode,
    input  logic                    lz_en,
    input  logic                    value_valid,
    output logic                    value_ready,
    output logic                    busy,
    input  logic [NUM_DIGITS-1:0]   blank,
    output logic [7*NUM_DIGITS-1:0] hex
);

    localparam int BCD_DIGITS = (DATA_WIDTH * 3) / 10 + 1;
    localparam int BCDW       = 4 * BCD_DIGITS;
    localparam int HEX_NIB    = (DATA_WIDTH + 3) / 4;
    localparam int SRC_DIG    = (BCD_DIGITS > HEX_NIB) ? BCD_DIGITS : HEX_NIB;
    localparam int EXT_DIG    = (SRC_DIG > NUM_DIGITS) ? SRC_DIG : NUM_DIGITS;
    localparam int EXTW       = 4 * EXT_DIG;
    localparam int CNTW       = $clog2(DATA_WIDTH + 1);
    localparam int SEGW       = 7 * NUM_DIGITS;

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (btn_raw[b]),
            .level (btn_level[b]),
            .pulse (btn_pulse[b])
        );
    end

    state_t                  state_q;
    state_t                  state_d;
    logic [DATA_WIDTH-1:0]   bin_q;
    logic [BCDW-1:0]         bcd_q;
    logic [CNTW-1:0]         cnt_q;
    logic                    hex_mode_q;
    logic                    neg_q;
    logic                    lz_q;
    logic [SEGW-1:0]         disp_q;
    logic [SEGW-1:0]         hex_q;

    logic                    accept;
    logic                    is_dec;
    logic                    neg_in;
    logic [DATA_WIDTH-1:0]   mag;
    logic [BCDW-1:0]         bcd_adj;
    logic [BCDW+DATA_WIDTH-1:0] dd_next;
    logic [EXTW-1:0]         src_ext;
    logic [SEGW-1:0]         fmt_seg;
    logic [SEGW-1:0]         blank_ext;
    logic                    ovf;
    int                      msd;

    assign value_ready = (state_q == ST_IDLE);
    assign busy        = ~value_ready;
    assign accept      = value_valid & value_ready;
    assign is_dec      = (mode == MODE_UDEC) || (mode == MODE_SDEC);
    assign neg_in      = (mode == MODE_SDEC) && value[DATA_WIDTH-1];
    // Negating the most negative value wraps to itself, which is its correct unsigned magnitude.
    assign mag         = neg_in ? -value : value;
    assign hex         = hex_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = is_dec ? ST_CONV : ST_FMT;
            ST_CONV: if (cnt_q == CNTW'(DATA_WIDTH - 1)) state_d = ST_FMT;
            ST_FMT:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        dd_next = {bcd_adj, bin_q} << 1;
    end

    // Hex mode formats the raw value held in bin_q; decimal formats the finished BCD.
    assign src_ext = hex_mode_q ? EXTW'(bin_q) : EXTW'(bcd_q);

    always_comb begin
        msd = 0;
        for (int i = 0; i < EXT_DIG; i++) begin
            if (src_ext[4*i +: 4] != 4'd0) msd = i;
        end
    end

    always_comb begin
        ovf     = (msd + 1 + int'(neg_q)) > NUM_DIGITS;
        fmt_seg = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            fmt_seg[7*d +: 7] = seg_encode(src_ext[4*d +: 4]);
            if (ovf) begin
                fmt_seg[7*d +: 7] = SEG_DASH;
            end else if (d > msd) begin
                if (lz_q) begin
                    fmt_seg[7*d +: 7] = (neg_q && d == msd + 1) ? SEG_DASH : SEG_BLANK;
                end else if (neg_q && d == NUM_DIGITS - 1) begin
                    fmt_seg[7*d +: 7] = SEG_DASH;
                end
            end
        end
    end

    always_comb begin
        blank_ext = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            blank_ext[7*d +: 7] = {7{blank[d]}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            hex_mode_q <= 1'b0;
            neg_q      <= 1'b0;
            lz_q       <= 1'b0;
            disp_q     <= {NUM_DIGITS{SEG_BLANK}};
            hex_q      <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        bin_q      <= mag;
                        bcd_q      <= '0;
                        cnt_q      <= '0;
                        hex_mode_q <= ~is_dec;
                        neg_q      <= neg_in;
                        lz_q       <= lz_en;
                    end
                end
                ST_CONV: begin
                    bcd_q <= dd_next[BCDW+DATA_WIDTH-1:DATA_WIDTH];
                    bin_q <= dd_next[DATA_WIDTH-1:0];
                    cnt_q <= cnt_q + 1'b1;
                end
                ST_FMT:  disp_q <= fmt_seg;
                default: ;
            endcase
            // Bypass the display register in FMT so the new value lands on the same edge.
            hex_q <= ((state_q == ST_FMT) ? fmt_seg : disp_q) | blank_ext;
        end
    end

endmodule

// File: tb/tb_board_io_ctrl.sv
// tb/tb_board_io_ctrl.sv - scoreboard bench for board_io_ctrl with directed vectors
module tb_board_io_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  btn_raw;
    logic [2:0]  btn_level;
    logic [2:0]  btn_pulse;
    logic [15:0] value;
    logic [1:0]  mode;
    logic        lz_en;
    logic        value_valid;
    logic        value_ready;
    logic        busy;
    logic [3:0]  blank;
    logic [27:0] hex;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       name;
        logic [27:0] hex;
        int          busy_cycles;
    } exp_t;

    exp_t sb[$];

    board_io_ctrl #(
        .NUM_BTN(3),
        .NUM_DIGITS(4),
        .DATA_WIDTH(16),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_pulse   (btn_pulse),
        .value       (value),
        .mode        (mode),
        .lz_en       (lz_en),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .busy        (busy),
        .blank       (blank),
        .hex         (hex)
    );

    always #5 clk = ~clk;

    function automatic logic [27:0] d4(input logic [6:0] d3, input logic [6:0] d2,
                                       input logic [6:0] d1, input logic [6:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        @(negedge clk);
        for (int i = 0; i < 100 && !value_ready; i++) @(negedge clk);
        check("idle_timeout", {31'd0, value_ready}, 32'd1);
    endtask

    task automatic send(input string name, input logic [15:0] v, input logic [1:0] m,
                        input logic lz, input logic [27:0] exp, input int bc, input bit push);
        wait_idle();
        if (push) sb.push_back('{name, exp, bc});
        value       = v;
        mode        = m;
        lz_en       = lz;
        value_valid = 1'b1;
        @(posedge clk);
        #1;
        value_valid = 1'b0;
    endtask

    // Monitor: a display update is presented when value_ready returns high.
    initial begin
        int   bcnt;
        logic prev;
        exp_t e;
        bcnt = 0;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bcnt = 0;
            end else if (!value_ready) begin
                bcnt++;
            end else if (!prev) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_update: got hex %h with no pending request", hex);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_hex"}, {4'd0, hex}, {4'd0, e.hex});
                    check({e.name, "_busy"}, bcnt, e.busy_cycles);
                end
                bcnt = 0;
            end
            prev = value_ready;
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        btn_raw     = 3'b000;
        value       = 16'd0;
        mode        = 2'b00;
        lz_en       = 1'b0;
        value_valid = 1'b0;
        blank       = 4'b0000;
        repeat (3) @(negedge clk);
        check("rst_hex",   {4'd0, hex}, 32'h0FFFFFFF);
        check("rst_level", {29'd0, btn_level}, 32'd0);
        check("rst_pulse", {29'd0, btn_pulse}, 32'd0);
        check("rst_ready", {31'd0, value_ready}, 32'd1);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        rst_n = 1'b1;

        // Debounce: 3-cycle glitch must not register, then a held press after 2+4 cycles.
        @(negedge clk);
        btn_raw = 3'b001;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("glitch_level", {29'd0, btn_level}, 32'd0);
        end
        btn_raw = 3'b000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("glitch_low_level", {29'd0, btn_level}, 32'd0);
        end
        btn_raw = 3'b001;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("hold_level_c%0d", k), {29'd0, btn_level}, (k >= 6) ? 32'd1 : 32'd0);
            check($sformatf("hold_pulse_c%0d", k), {29'd0, btn_pulse}, (k == 6) ? 32'd1 : 32'd0);
        end
        btn_raw = 3'b000;

        send("hex_0a3f", 16'h0A3F, 2'b00, 1'b0, d4(7'h40, 7'h08, 7'h30, 7'h0E), 1, 1'b1);
        wait_idle();
        blank = 4'b0001;
        @(negedge clk);
        check("blank_d0", {4'd0, hex}, {4'd0, d4(7'h40, 7'h08, 7'h30, 7'h7F)});
        blank = 4'b0000;
        @(negedge clk);
        check("unblank_d0", {4'd0, hex}, {4'd0, d4(7'h40, 7'h08, 7'h30, 7'h0E)});

        send("hex_beef_m11", 16'hBEEF, 2'b11, 1'b1, d4(7'h03, 7'h06, 7'h06, 7'h0E), 1, 1'b1);

        send("udec_1234", 16'd1234, 2'b01, 1'b0, d4(7'h79, 7'h24, 7'h30, 7'h19), 17, 1'b1);
        repeat (5) @(negedge clk);
        value       = 16'd9;
        mode        = 2'b00;
        value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;

        send("sdec_m7_lz",    16'hFFF9, 2'b10, 1'b1, d4(7'h7F, 7'h7F, 7'h3F, 7'h78), 17, 1'b1);
        send("sdec_m7_nolz",  16'hFFF9, 2'b10, 1'b0, d4(7'h3F, 7'h40, 7'h40, 7'h78), 17, 1'b1);
        send("sdec_8000",     16'h8000, 2'b10, 1'b1, d4(7'h3F, 7'h3F, 7'h3F, 7'h3F), 17, 1'b1);
        send("sdec_42_lz",    16'd42,   2'b10, 1'b1, d4(7'h7F, 7'h7F, 7'h19, 7'h24), 17, 1'b1);
        send("sdec_m999",     16'hFC19, 2'b10, 1'b1, d4(7'h3F, 7'h10, 7'h10, 7'h10), 17, 1'b1);
        send("sdec_m1000",    16'hFC18, 2'b10, 1'b1, d4(7'h3F, 7'h3F, 7'h3F, 7'h3F), 17, 1'b1);
        send("udec_9999",     16'd9999, 2'b01, 1'b1, d4(7'h10, 7'h10, 7'h10, 7'h10), 17, 1'b1);
        send("udec_0_lz",     16'd0,    2'b01, 1'b1, d4(7'h7F, 7'h7F, 7'h7F, 7'h40), 17, 1'b1);
        send("udec_12345",    16'd12345, 2'b01, 1'b0, d4(7'h3F, 7'h3F, 7'h3F, 7'h3F), 17, 1'b1);

        // Reset in the middle of a decimal conversion.
        send("udec_abort", 16'd4321, 2'b01, 1'b0, 28'd0, 17, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_hex",   {4'd0, hex}, 32'h0FFFFFFF);
        check("abort_ready", {31'd0, value_ready}, 32'd1);
        check("abort_busy",  {31'd0, busy}, 32'd0);
        rst_n = 1'b1;

        send("hex_0_lz", 16'h0000, 2'b00, 1'b1, d4(7'h7F, 7'h7F, 7'h7F, 7'h40), 1, 1'b1);
        wait_idle();
        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
